// File: rtl/icache_pkg.sv
// Shared geometry, FSM encoding and address-field helpers for the direct-mapped
// instruction cache.
package icache_pkg;

    localparam int NUM_LINES  = 32;
    localparam int LINE_BITS  = 256;
    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int INDEX_W    = 5;
    localparam int TAG_W      = 22;
    localparam int LADDR_W    = 32 - OFFSET_W;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [INDEX_W-1:0]   index_t;
    typedef logic [LADDR_W-1:0]   laddr_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MISS   = 2'd1;
    localparam state_t ST_REFILL = 2'd2;

    function automatic index_t addr_index(input logic [31:0] addr);
        return addr[9:5];
    endfunction

    function automatic tag_t addr_tag(input logic [31:0] addr);
        return addr[31:10];
    endfunction

endpackage

// File: rtl/icache_array_if.sv
// Read/write/clear bundle between the cache controller and its storage array.
interface icache_array_if;
    import icache_pkg::*;

    index_t rd_index;
    line_t  rd_line;
    tag_t   rd_tag;
    logic   rd_valid;

    logic   wr_en;
    index_t wr_index;
    tag_t   wr_tag;
    line_t  wr_line;
    logic   clear_all;

    modport master (
        output rd_index, wr_en, wr_index, wr_tag, wr_line, clear_all,
        input  rd_line, rd_tag, rd_valid
    );

    modport slave (
        input  rd_index, wr_en, wr_index, wr_tag, wr_line, clear_all,
        output rd_line, rd_tag, rd_valid
    );

endinterface

// File: rtl/icache_array.sv
// Data, tag and valid storage: synchronous write, asynchronous read, and a
// clear-all-valid input that wins over a simultaneous line write.
module icache_array
    import icache_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    icache_array_if.slave  arr
);

    line_t                 data_q [NUM_LINES];
    tag_t                  tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;

    // NOTE: data and tag RAMs carry no reset; only the valid bits need a known
    // state, which keeps the arrays mappable onto plain memory.
    always_ff @(posedge clk_i) begin
        if (arr.wr_en) begin
            data_q[arr.wr_index] <= arr.wr_line;
            tag_q[arr.wr_index]  <= arr.wr_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (arr.clear_all) begin
            valid_q <= '0;
        end else if (arr.wr_en) begin
            valid_q[arr.wr_index] <= 1'b1;
        end
    end

    assign arr.rd_line  = data_q[arr.rd_index];
    assign arr.rd_tag   = tag_q[arr.rd_index];
    assign arr.rd_valid = valid_q[arr.rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: combinational hit path, a
// three-state refill FSM towards block memory, and saturating hit/miss counters.
module icache_controller
    import icache_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic [31:0]  cpu_addr_i,
    output logic [31:0]  cpu_instr_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    input  logic         invalidate_i,
    output logic [15:0]  hit_cnt_o,
    output logic [15:0]  miss_cnt_o
);

    state_t       state_q, state_d;
    laddr_t       laddr_q, laddr_d;
    logic         inv_pend_q, inv_pend_d;
    line_t        fill_q;
    logic [15:0]  hit_cnt_q, hit_cnt_d;
    logic [15:0]  miss_cnt_q, miss_cnt_d;

    logic         hit;
    logic         in_idle;
    logic         unused_addr_bits;

    icache_array_if arr_if ();

    icache_array u_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .arr   (arr_if.slave)
    );

    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign in_idle         = (state_q == ST_IDLE);
    assign arr_if.rd_index = addr_index(cpu_addr_i);
    assign hit             = cpu_req_i && arr_if.rd_valid
                             && (arr_if.rd_tag == addr_tag(cpu_addr_i));

    // The refill writes from the latched line address, never from cpu_addr_i.
    assign arr_if.wr_en    = !rst_i && (state_q == ST_REFILL);
    assign arr_if.wr_index = laddr_q[INDEX_W-1:0];
    assign arr_if.wr_tag   = laddr_q[LADDR_W-1:INDEX_W];
    assign arr_if.wr_line  = fill_q;
    assign arr_if.clear_all = !rst_i
        && ((in_idle && invalidate_i)
            || ((state_q == ST_REFILL) && (inv_pend_q || invalidate_i)));

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        laddr_d    = laddr_q;
        inv_pend_d = inv_pend_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hit && hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_d = hit_cnt_q + 16'd1;
                end
                if (cpu_req_i && !hit) begin
                    state_d = ST_MISS;
                    laddr_d = cpu_addr_i[31:OFFSET_W];
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                end
            end
            ST_MISS: begin
                if (invalidate_i) begin
                    inv_pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                state_d    = ST_IDLE;
                inv_pend_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            laddr_q    <= '0;
            inv_pend_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            laddr_q    <= laddr_d;
            inv_pend_q <= inv_pend_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_MISS && mem_ack_i) begin
            fill_q <= mem_data_i;
        end
    end

    assign cpu_stall_o  = !rst_i && (in_idle ? (cpu_req_i && !hit) : 1'b1);
    assign cpu_instr_o  = (!rst_i && in_idle && hit)
                          ? arr_if.rd_line[{cpu_addr_i[4:2], 5'b0} +: 32]
                          : NOP_INSTR;
    assign mem_enable_o = !rst_i && (state_q == ST_MISS);
    assign mem_addr_o   = mem_enable_o ? {laddr_q, {OFFSET_W{1'b0}}} : 32'h0;
    assign mem_write_o  = 1'b0;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a fixed-latency block-memory model
// whose line contents are a known function of the line address.
module tb_icache_controller;

    localparam int LATENCY = 10;
    localparam int BOUND   = 200;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b1;
    logic [31:0]  cpu_addr_i = 32'h40;
    logic [31:0]  cpu_instr_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic [31:0]  mem_addr_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic         invalidate_i = 1'b0;
    logic [15:0]  hit_cnt_o;
    logic [15:0]  miss_cnt_o;

    int           n_checks = 0;
    int           n_fail = 0;
    bit           auto_ack = 1'b1;
    int           resp_cnt = 0;
    int           en_cycles = 0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  last_ack_addr = '0;
    bit           addr_moved = 1'b0;
    bit           wr_seen = 1'b0;

    icache_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_instr_o  (cpu_instr_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_addr_o   (mem_addr_o),
        .mem_write_o  (mem_write_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .invalidate_i (invalidate_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Word w of the line at byte address a reads {16'hC0DE, a[15:0] + 4*w}.
    function automatic logic [255:0] make_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = {16'hC0DE, a[15:0] + 16'(w * 4)};
        end
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory model: ack in the LATENCY-th enabled cycle, data from mem_addr_o.
    always @(negedge clk_i) begin
        if (mem_write_o !== 1'b0) wr_seen = 1'b1;
        if (mem_enable_o) en_cycles++;
        if (auto_ack) begin
            if (mem_enable_o) begin
                resp_cnt++;
                if (resp_cnt == 1) req_addr = mem_addr_o;
                else if (mem_addr_o !== req_addr) addr_moved = 1'b1;
                if (resp_cnt == LATENCY) begin
                    mem_ack_i     = 1'b1;
                    mem_data_i    = make_line(mem_addr_o);
                    last_ack_addr = mem_addr_o;
                end
            end else begin
                mem_ack_i = 1'b0;
                resp_cnt  = 0;
            end
        end
    end

    // Present a fetch and wait until it is served; inv_at pulses invalidate_i
    // in that stalled cycle of the fetch.
    task automatic fetch(input logic [31:0] a, input int inv_at,
                         output logic [31:0] instr, output int stalls);
        @(negedge clk_i);
        cpu_addr_i   = a;
        cpu_req_i    = 1'b1;
        invalidate_i = 1'b0;
        stalls       = 0;
        #1;
        while (cpu_stall_o && stalls < BOUND) begin
            stalls++;
            @(negedge clk_i);
            invalidate_i = (stalls == inv_at);
            #1;
        end
        instr = cpu_instr_o;
        check("fetch_bound", 32'(stalls < BOUND), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i        = 1'b1;
        cpu_req_i    = 1'b0;
        invalidate_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        logic [31:0] instr;
        int          stalls;

        // Reset asserted with a request pending: outputs forced quiet.
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_stall", 32'(cpu_stall_o), 32'd0);
        check("rst_instr", cpu_instr_o, 32'h0000_0013);
        check("rst_men", 32'(mem_enable_o), 32'd0);
        check("rst_maddr", mem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        #1;
        check("rst_hits", 32'(hit_cnt_o), 32'd0);
        check("rst_misses", 32'(miss_cnt_o), 32'd0);
        check("rst_idle_instr", cpu_instr_o, 32'h0000_0013);

        // Cold fetch: 10 memory cycles, 12 stall cycles, word 0.
        en_cycles = 0;
        fetch(32'h40, -1, instr, stalls);
        check("cold_stalls", 32'(stalls), 32'd12);
        check("cold_en_cycles", 32'(en_cycles), 32'd10);
        check("cold_mem_addr", last_ack_addr, 32'h40);
        check("cold_instr", instr, 32'hC0DE_0040);
        check("cold_misses", 32'(miss_cnt_o), 32'd1);

        // Walk the filled line: every word hits without memory traffic.
        en_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            fetch(32'h40 + 32'(4 * i), -1, instr, stalls);
            check("seq_stalls", 32'(stalls), 32'd0);
            check("seq_instr", instr, 32'hC0DE_0040 + 32'(4 * i));
        end
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        #1;
        check("seq_en_cycles", 32'(en_cycles), 32'd0);
        check("seq_hits", 32'(hit_cnt_o), 32'd9);

        // Conflict on index 2: 0x440 evicts 0x40, then 0x40 evicts 0x440.
        fetch(32'h440, -1, instr, stalls);
        check("conf1_stalls", 32'(stalls), 32'd12);
        check("conf1_mem_addr", last_ack_addr, 32'h440);
        check("conf1_instr", instr, 32'hC0DE_0440);
        fetch(32'h40, -1, instr, stalls);
        check("conf2_stalls", 32'(stalls), 32'd12);
        check("conf2_instr", instr, 32'hC0DE_0040);
        check("conf_misses", 32'(miss_cnt_o), 32'd3);

        // Invalidate in the 3rd MISS cycle: refilled line is dropped, refetch.
        do_reset();
        fetch(32'h80, 3, instr, stalls);
        check("inv_stalls", 32'(stalls), 32'd24);
        check("inv_instr", instr, 32'hC0DE_0080);
        check("inv_misses", 32'(miss_cnt_o), 32'd2);

        // Invalidate in IDLE: the same-cycle hit still returns the old word.
        @(negedge clk_i);
        cpu_addr_i   = 32'h84;
        cpu_req_i    = 1'b1;
        invalidate_i = 1'b1;
        #1;
        check("idle_inv_stall", 32'(cpu_stall_o), 32'd0);
        check("idle_inv_instr", cpu_instr_o, 32'hC0DE_0084);
        fetch(32'h84, -1, instr, stalls);
        check("idle_inv_refetch", 32'(stalls), 32'd12);
        check("idle_inv_misses", 32'(miss_cnt_o), 32'd3);

        // Reset in the 3rd MISS cycle, then a stray ack 5 cycles later.
        do_reset();
        auto_ack = 1'b0;
        @(negedge clk_i);
        cpu_addr_i = 32'hC0;
        cpu_req_i  = 1'b1;
        #1;
        check("mrst_miss_stall", 32'(cpu_stall_o), 32'd1);
        repeat (3) @(negedge clk_i);
        #1;
        check("mrst_en_before", 32'(mem_enable_o), 32'd1);
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        #1;
        check("mrst_en_in_rst", 32'(mem_enable_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("mrst_en_after", 32'(mem_enable_o), 32'd0);
        repeat (4) @(negedge clk_i);
        mem_ack_i  = 1'b1;
        mem_data_i = make_line(32'hC0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check("mrst_en_late_ack", 32'(mem_enable_o), 32'd0);
        check("mrst_hits", 32'(hit_cnt_o), 32'd0);
        check("mrst_misses", 32'(miss_cnt_o), 32'd0);
        auto_ack = 1'b1;
        fetch(32'hC0, -1, instr, stalls);
        check("mrst_no_write", 32'(stalls), 32'd12);
        check("mrst_instr", instr, 32'hC0DE_00C0);

        // No request: NOP, no stall, counters frozen.
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check("noreq_stall", 32'(cpu_stall_o), 32'd0);
        check("noreq_instr", cpu_instr_o, 32'h0000_0013);
        check("noreq_hits", 32'(hit_cnt_o), 32'd1);
        check("noreq_misses", 32'(miss_cnt_o), 32'd1);

        // Hold a hit for 70000 cycles: the hit counter saturates.
        fetch(32'hC4, -1, instr, stalls);
        check("sat_first_hit", 32'(stalls), 32'd0);
        repeat (70000) @(negedge clk_i);
        #1;
        check("sat_hits", 32'(hit_cnt_o), 32'h0000_FFFF);
        check("sat_misses", 32'(miss_cnt_o), 32'd1);
        check("sat_stall", 32'(cpu_stall_o), 32'd0);

        check("mem_addr_stable", 32'(addr_moved), 32'd0);
        check("mem_write_low", 32'(wr_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
